fib_fill_ctrl: RTL and testbench

- FSM-driven producer sitting directly upstream of the 64x32 register file (1 combinational read port, 1 write port).
- On start, writes a Fibonacci-type sequence into consecutive register-file entries: f[0]=seed0, f[1]=seed1, f[i]=f[i-1]+f[i-2] (mod 2^32).
- f[i-2] is fetched back through the register-file read port; f[i-1] is held locally.
- Reports completion, final value and any carry-out seen.

---
 rtl/fib_fill_ctrl_pkg.sv | 17 +
 rtl/fib_fill_ctrl.sv | 159 +++++++++++++++
 tb/tb_fib_fill_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fib_fill_ctrl_pkg.sv
// Shared definitions for the Fibonacci fill controller and its register file:
// FSM state encoding and default geometry.
package fib_fill_ctrl_pkg;

  localparam int RF_AW = 6;
  localparam int RF_DW = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    RD   = 3'd3,
    ADD  = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/fib_fill_ctrl.sv
// Fills consecutive register-file entries with f[i] = f[i-1] + f[i-2], reading
// f[i-2] back through the register file and keeping f[i-1] locally.
module fib_fill_ctrl
  import fib_fill_ctrl_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] seed0,
  input  logic [DW-1:0] seed1,
  input  logic [AW:0]   len,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_wena,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [DW-1:0] last_val
);

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] TWO     = (AW+1)'(2);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(1 << AW);

  state_e        state_q, state_d;
  // idx carries one extra bit so a full-depth run reaches its last address
  // without wrapping before the DONE decision.
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] seed0_q, seed0_d;
  logic [DW-1:0] seed1_q, seed1_d;
  logic [DW-1:0] prev_q, prev_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] last_val_q, last_val_d;
  logic          ovf_q, ovf_d;
  logic [DW:0]   sum;

  assign sum = {1'b0, opa_q} + {1'b0, prev_q};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      seed0_q    <= '0;
      seed1_q    <= '0;
      prev_q     <= '0;
      opa_q      <= '0;
      last_val_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      seed0_q    <= seed0_d;
      seed1_q    <= seed1_d;
      prev_q     <= prev_d;
      opa_q      <= opa_d;
      last_val_q <= last_val_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    seed0_d    = seed0_q;
    seed1_d    = seed1_q;
    prev_d     = prev_q;
    opa_d      = opa_q;
    last_val_d = last_val_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = W0;
          seed0_d    = seed0;
          seed1_d    = seed1;
          ovf_d      = 1'b0;
          last_val_d = '0;
          if (len < TWO)          len_d = TWO;
          else if (len > LEN_MAX) len_d = LEN_MAX;
          else                    len_d = len;
        end
      end
      W0: state_d = W1;
      W1: begin
        prev_d     = seed1_q;
        last_val_d = seed1_q;
        idx_d      = TWO;
        state_d    = (len_q > TWO) ? RD : DONE;
      end
      RD: begin
        opa_d   = rf_rdata;
        state_d = ADD;
      end
      ADD: begin
        ovf_d      = ovf_q | sum[DW];
        prev_d     = sum[DW-1:0];
        last_val_d = sum[DW-1:0];
        if (idx_q == len_q - ONE) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ONE;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_raddr = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_wena  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      W0: begin
        rf_wena  = 1'b1;
        rf_wdata = seed0_q;
        busy     = 1'b1;
      end
      W1: begin
        rf_wena  = 1'b1;
        rf_waddr = AW'(1);
        rf_wdata = seed1_q;
        busy     = 1'b1;
      end
      RD: begin
        rf_raddr = AW'(idx_q - TWO);
        busy     = 1'b1;
      end
      ADD: begin
        rf_wena  = 1'b1;
        rf_waddr = AW'(idx_q);
        rf_wdata = sum[DW-1:0];
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign ovf      = ovf_q;
  assign last_val = last_val_q;

endmodule

// File: tb/tb_fib_fill_ctrl.sv
// Bench for fib_fill_ctrl: models the register file, and checks each run
// against a sequence computed directly from the recurrence.
module tb_fib_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] seed0, seed1;
  logic [6:0]  len;
  logic [5:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_wena, busy, done, ovf;
  logic [31:0] last_val;

  logic [31:0] mem [64];
  int          wr_cnt = 0;
  int          wr_hits [64];
  int          n_checks = 0;
  int          n_errors = 0;

  fib_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .seed0(seed0), .seed1(seed1), .len(len),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wena(rf_wena),
    .busy(busy), .done(done), .ovf(ovf), .last_val(last_val)
  );

  always #5 clk = ~clk;

  assign rf_rdata = mem[rf_raddr];

  initial for (int i = 0; i < 64; i++) wr_hits[i] = 0;

  always @(posedge clk) begin
    if (rf_wena) begin
      mem[rf_waddr] <= rf_wdata;
      wr_cnt = wr_cnt + 1;
      wr_hits[rf_waddr] = wr_hits[rf_waddr] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".rf_raddr"}, 64'(rf_raddr), 0);
    check({tag, ".rf_waddr"}, 64'(rf_waddr), 0);
    check({tag, ".rf_wdata"}, 64'(rf_wdata), 0);
    check({tag, ".rf_wena"},  64'(rf_wena),  0);
    check({tag, ".busy"},     64'(busy),     0);
    check({tag, ".done"},     64'(done),     0);
    check({tag, ".ovf"},      64'(ovf),      0);
    check({tag, ".last_val"}, 64'(last_val), 0);
  endtask

  // One complete run; extra_at >= 1 pulses a second start that many cycles in.
  task automatic run(input logic [31:0] s0, input logic [31:0] s1,
                     input logic [6:0] ln, input int extra_at, input string name);
    logic [31:0] e [64];
    logic [32:0] s;
    logic        ovf_exp;
    int          lc, cyc, cnt0, bad;
    int          hits0 [64];

    lc = (ln < 2) ? 2 : ((ln > 64) ? 64 : int'(ln));
    e[0] = s0;
    e[1] = s1;
    ovf_exp = 1'b0;
    for (int i = 2; i < lc; i++) begin
      s = {1'b0, e[i-1]} + {1'b0, e[i-2]};
      e[i] = s[31:0];
      if (s[32]) ovf_exp = 1'b1;
    end

    @(negedge clk);
    cnt0 = wr_cnt;
    for (int i = 0; i < 64; i++) hits0[i] = wr_hits[i];
    seed0 = s0; seed1 = s1; len = ln; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        check({name, ".busy_after_start"}, 64'(busy), 1);
        check({name, ".done_after_start"}, 64'(done), 0);
        check({name, ".ovf_cleared"}, 64'(ovf), 0);
        seed0 = $urandom; seed1 = $urandom; len = 7'($urandom);
      end
      if (done || cyc >= 300) begin
        start = 1'b0;
        break;
      end
      start = (cyc == extra_at);
      @(posedge clk);
      cyc++;
    end

    check({name, ".latency"}, 64'(cyc), 64'(2 + 2 * (lc - 2)));
    check({name, ".done"}, 64'(done), 1);
    check({name, ".busy"}, 64'(busy), 0);
    check({name, ".writes"}, 64'(wr_cnt - cnt0), 64'(lc));
    for (int i = 0; i < lc; i++)
      check($sformatf("%s.mem[%0d]", name, i), 64'(mem[i]), 64'(e[i]));
    bad = 0;
    for (int i = 0; i < 64; i++)
      if ((wr_hits[i] - hits0[i]) != ((i < lc) ? 1 : 0)) bad++;
    check({name, ".addr_hit_pattern"}, 64'(bad), 0);
    check({name, ".last_val"}, 64'(last_val), 64'(e[lc-1]));
    check({name, ".ovf"}, 64'(ovf), 64'(ovf_exp));
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; seed0 = '0; seed1 = '0; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run(32'd1, 32'd1, 7'd10, -1, "fib10");
    run(32'd0, 32'd1, 7'd64, -1, "fib64");
    check("fib64.entry47", 64'(mem[47]), 64'd2971215073);
    check("fib64.entry48", 64'(mem[48]), 64'd512559680);
    run(32'd2, 32'd3, 7'd4, -1, "restart");
    run(32'd7, 32'd9, 7'd2, -1, "len2");
    run(32'd7, 32'd9, 7'd0, -1, "len0");
    run(32'd1, 32'd1, 7'd100, -1, "len100");
    run(32'd1, 32'd1, 7'd10, 3, "ignored_start");

    // Reset pulse while reading for idx=5 (read address 3).
    @(negedge clk);
    seed0 = 32'd1; seed1 = 32'd1; len = 7'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(busy && !rf_wena && rf_raddr == 6'd3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midrst.reached_rd", 64'(guard < 100), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("midrst");
    run(32'd5, 32'd8, 7'd12, -1, "after_rst");

    for (int k = 0; k < 6; k++)
      run($urandom, $urandom, 7'($urandom_range(0, 127)),
          int'($urandom_range(1, 6)), $sformatf("rand%0d", k));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
